// File: rtl/sort_6_frame_gather.sv
// Stream-to-frame gatherer for the 6-input sort network.
// Packs six consecutive valid/ready words into one registered frame on data_0..data_5.
// Optional feature macro: SORT_GATHER_FLUSH_EN adds a flush input that closes a partial
// frame, padding the unfilled lanes with PAD_VALUE and reporting their count on out_pad.
module sort_6_frame_gather #(
  parameter int unsigned       DATA_W    = 32,
  parameter logic [DATA_W-1:0] PAD_VALUE = {DATA_W{1'b1}},
  parameter int unsigned       CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data_0,
  output logic [DATA_W-1:0] data_1,
  output logic [DATA_W-1:0] data_2,
  output logic [DATA_W-1:0] data_3,
  output logic [DATA_W-1:0] data_4,
  output logic [DATA_W-1:0] data_5,
  output logic [2:0]        out_pad,
  output logic [CNT_W-1:0]  frames_out
`ifdef SORT_GATHER_FLUSH_EN
  ,
  input  logic              flush
`endif
);

  localparam int unsigned LANES    = 6;
  localparam int unsigned ASM_N    = 5;
  localparam logic [2:0]  LAST_IDX = 3'd5;
  localparam logic [2:0]  FULL_CNT = 3'd5;

  logic [2:0]        wr_cnt;
  logic [DATA_W-1:0] asm_q  [ASM_N];
  logic [DATA_W-1:0] lane_q [LANES];
  logic [DATA_W-1:0] lane_d [LANES];

  logic       accept;
  logic       handoff;
  logic       bank_free;
  logic       frame_load;
  logic       flush_load;
  logic       bank_load;
  logic       flush_pend;
  logic [2:0] fill_cnt;
  logic [2:0] pad_d;

  assign bank_free  = !out_valid || out_ready;
  // out_ready only reaches in_ready when the next word would complete a frame.
  assign in_ready   = !rst && !flush_pend && ((wr_cnt != LAST_IDX) || bank_free);
  assign accept     = in_valid && in_ready;
  assign handoff    = out_valid && out_ready;
  assign frame_load = accept && (wr_cnt == LAST_IDX);
  assign bank_load  = frame_load || flush_load;

`ifdef SORT_GATHER_FLUSH_EN
  logic [2:0] wr_cnt_after;

  // Fill level once this cycle's accept is counted; a completing accept empties the bank.
  always_comb begin
    wr_cnt_after = wr_cnt;
    if (accept) begin
      wr_cnt_after = frame_load ? 3'd0 : wr_cnt + 3'd1;
    end
  end

  assign flush_load = flush_pend && bank_free;
  assign fill_cnt   = flush_load ? wr_cnt : FULL_CNT;
  assign pad_d      = flush_load ? 3'd6 - wr_cnt : 3'd0;

  // Flush request latch: armed only when words remain, released when the padded frame loads.
  always_ff @(posedge clk) begin
    if (rst) begin
      flush_pend <= 1'b0;
    end else if (flush_load) begin
      flush_pend <= 1'b0;
    end else if (flush && (wr_cnt_after != 3'd0)) begin
      flush_pend <= 1'b1;
    end
  end
`else
  assign flush_pend = 1'b0;
  assign flush_load = 1'b0;
  assign fill_cnt   = FULL_CNT;
  assign pad_d      = 3'd0;
`endif

  // Next frame contents: filled assembly lanes, then PAD_VALUE; lane 5 takes the live word on completion.
  always_comb begin
    for (int k = 0; k < int'(ASM_N); k++) begin
      lane_d[k] = (3'(k) < fill_cnt) ? asm_q[k] : PAD_VALUE;
    end
    lane_d[LANES-1] = frame_load ? in_data : PAD_VALUE;
  end

  // Write index of the assembly bank.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt <= 3'd0;
    end else if (bank_load) begin
      wr_cnt <= 3'd0;
    end else if (accept) begin
      wr_cnt <= wr_cnt + 3'd1;
    end
  end

  // Assembly bank capture of words 0..4.
  always_ff @(posedge clk) begin
    for (int k = 0; k < int'(ASM_N); k++) begin
      if (accept && (wr_cnt == 3'(k))) begin
        asm_q[k] <= in_data;
      end
    end
  end

  // Output bank: loads a frame, holds it until handoff, keeps lanes after handoff.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_pad   <= 3'd0;
      for (int k = 0; k < int'(LANES); k++) begin
        lane_q[k] <= '0;
      end
    end else if (bank_load) begin
      out_valid <= 1'b1;
      out_pad   <= pad_d;
      for (int k = 0; k < int'(LANES); k++) begin
        lane_q[k] <= lane_d[k];
      end
    end else if (handoff) begin
      out_valid <= 1'b0;
    end
  end

  // Handoff counter, wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      frames_out <= '0;
    end else if (handoff) begin
      frames_out <= frames_out + CNT_W'(1);
    end
  end

  assign data_0 = lane_q[0];
  assign data_1 = lane_q[1];
  assign data_2 = lane_q[2];
  assign data_3 = lane_q[3];
  assign data_4 = lane_q[4];
  assign data_5 = lane_q[5];

endmodule

// File: tb/tb_sort_6_frame_gather.sv
// Self-checking bench for sort_6_frame_gather: directed scenarios plus random traffic,
// checked every cycle against a queue-based model of the gatherer.
module tb_sort_6_frame_gather;

  localparam logic [31:0] PAD = 32'hFFFF_FFFF;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] data_0, data_1, data_2, data_3, data_4, data_5;
  logic [2:0]  out_pad;
  logic [15:0] frames_out;
  logic        flush_drv;
  logic [31:0] dl [6];

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: words gathered so far, the held frame, and bookkeeping.
  logic [31:0] q_words [$];
  logic [31:0] m_lanes [6];
  logic        m_valid;
  logic [2:0]  m_pad;
  logic [15:0] m_frames;
  logic        m_pend;

  sort_6_frame_gather #(
    .DATA_W   (32),
    .PAD_VALUE(32'hFFFF_FFFF),
    .CNT_W    (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_0    (data_0),
    .data_1    (data_1),
    .data_2    (data_2),
    .data_3    (data_3),
    .data_4    (data_4),
    .data_5    (data_5),
    .out_pad   (out_pad),
    .frames_out(frames_out)
`ifdef SORT_GATHER_FLUSH_EN
    ,
    .flush     (flush_drv)
`endif
  );

  assign dl[0] = data_0;
  assign dl[1] = data_1;
  assign dl[2] = data_2;
  assign dl[3] = data_3;
  assign dl[4] = data_4;
  assign dl[5] = data_5;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check in_ready, advance the model, then check registered outputs.
  task automatic cycle(input logic v, input logic [31:0] d, input logic ordy,
                       input logic r, input logic fl, output logic acc);
    logic exp_rdy;
    logic hand;
    logic vb;
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    rst       = r;
    flush_drv = fl;
    #1;
    exp_rdy = !r && !m_pend && (q_words.size() != 5 || !m_valid || ordy);
    check("in_ready", in_ready, exp_rdy);
    acc  = v && exp_rdy;
    hand = m_valid && ordy;
    vb   = m_valid;
    if (r) begin
      q_words.delete();
      for (int k = 0; k < 6; k++) m_lanes[k] = '0;
      m_valid  = 1'b0;
      m_pad    = 3'd0;
      m_frames = '0;
      m_pend   = 1'b0;
    end else begin
      if (hand) begin
        m_frames = m_frames + 16'd1;
        m_valid  = 1'b0;
      end
      if (acc) begin
        q_words.push_back(d);
        if (q_words.size() == 6) begin
          for (int k = 0; k < 6; k++) m_lanes[k] = q_words[k];
          m_pad   = 3'd0;
          m_valid = 1'b1;
          q_words.delete();
        end
      end
`ifdef SORT_GATHER_FLUSH_EN
      if (m_pend && (!vb || ordy)) begin
        for (int k = 0; k < 6; k++) m_lanes[k] = (k < q_words.size()) ? q_words[k] : PAD;
        m_pad   = 3'(6 - q_words.size());
        m_valid = 1'b1;
        m_pend  = 1'b0;
        q_words.delete();
      end else if (fl && q_words.size() != 0) begin
        m_pend = 1'b1;
      end
`endif
    end
    @(posedge clk);
    @(negedge clk);
    check("out_valid", out_valid, m_valid);
    for (int k = 0; k < 6; k++) check($sformatf("data_%0d", k), dl[k], m_lanes[k]);
    check("out_pad", out_pad, m_pad);
    check("frames_out", frames_out, m_frames);
  endtask

  // Offer a word until it is accepted, bounded.
  task automatic send_word(input logic [31:0] d, input logic ordy);
    logic a;
    int   n;
    a = 1'b0;
    n = 0;
    while (!a && n < 20) begin
      cycle(1'b1, d, ordy, 1'b0, 1'b0, a);
      n++;
    end
    check("send_word_accepted", a, 1'b1);
  endtask

  task automatic idle(input logic ordy);
    logic a;
    cycle(1'b0, 32'd0, ordy, 1'b0, 1'b0, a);
  endtask

  task automatic do_reset(input int n);
    logic a;
    for (int i = 0; i < n; i++) cycle(1'b1, $urandom, 1'b0, 1'b1, 1'b0, a);
  endtask

  initial begin
    logic a;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush_drv = 1'b0;
    m_valid = 1'b0; m_pad = '0; m_frames = '0; m_pend = 1'b0;
    for (int k = 0; k < 6; k++) m_lanes[k] = '0;

    // T1 reset held with in_valid high
    do_reset(3);
    check("t1_in_ready_in_reset", in_ready, 1'b0);
    check("t1_out_valid", out_valid, 1'b0);
    check("t1_data_0", data_0, 32'd0);
    check("t1_data_5", data_5, 32'd0);
    check("t1_frames_out", frames_out, 16'd0);
    idle(1'b0);
    check("t1_in_ready_after", in_ready, 1'b1);

    // T2 streaming at full rate
    for (int i = 1; i <= 12; i++) begin
      cycle(1'b1, 32'(i), 1'b1, 1'b0, 1'b0, a);
      check("t2_accept", a, 1'b1);
      if (i == 6 || i == 12) begin
        check("t2_out_valid", out_valid, 1'b1);
        for (int k = 0; k < 6; k++) check("t2_lane", dl[k], 32'(i - 5 + k));
      end
    end
    idle(1'b1);
    check("t2_frames_out", frames_out, 16'd2);

    // T3 backpressure
    for (int i = 1; i <= 11; i++) send_word(32'(i), 1'b0);
    cycle(1'b1, 32'd12, 1'b0, 1'b0, 1'b0, a);
    check("t3_w12_stalled", a, 1'b0);
    check("t3_in_ready_full", in_ready, 1'b0);
    check("t3_hold_d0", data_0, 32'd1);
    check("t3_hold_d5", data_5, 32'd6);
    cycle(1'b1, 32'd12, 1'b1, 1'b0, 1'b0, a);
    check("t3_w12_accept", a, 1'b1);
    check("t3_frame2_valid", out_valid, 1'b1);
    check("t3_frame2_d0", data_0, 32'd7);
    check("t3_frame2_d5", data_5, 32'd12);
    send_word(32'd13, 1'b0);

    // T4 reset mid-frame
    for (int i = 0; i < 3; i++) send_word(32'(100 + i), 1'b1);
    do_reset(1);
    for (int i = 20; i <= 25; i++) send_word(32'(i), 1'b0);
    for (int k = 0; k < 6; k++) check("t4_lane", dl[k], 32'(20 + k));
    idle(1'b1);
    check("t4_frames_out", frames_out, 16'd1);
    idle(1'b1);
    check("t4_no_extra", out_valid, 1'b0);

`ifdef SORT_GATHER_FLUSH_EN
    // T5 flush of a partial frame, then flush on an empty bank
    do_reset(1);
    send_word(32'd4, 1'b1);
    send_word(32'd9, 1'b1);
    cycle(1'b0, 32'd0, 1'b1, 1'b0, 1'b1, a);
    idle(1'b1);
    check("t5_valid", out_valid, 1'b1);
    check("t5_d0", data_0, 32'd4);
    check("t5_d1", data_1, 32'd9);
    check("t5_d2", data_2, PAD);
    check("t5_d5", data_5, PAD);
    check("t5_pad", out_pad, 3'd4);
    idle(1'b1);
    cycle(1'b0, 32'd0, 1'b1, 1'b0, 1'b1, a);
    idle(1'b1);
    idle(1'b1);
    check("t5_empty_flush", out_valid, 1'b0);

    // T6 flush coinciding with the completing accept
    for (int i = 1; i <= 5; i++) send_word(32'(50 + i), 1'b1);
    cycle(1'b1, 32'd56, 1'b1, 1'b0, 1'b1, a);
    check("t6_accept", a, 1'b1);
    check("t6_valid", out_valid, 1'b1);
    check("t6_pad", out_pad, 3'd0);
    check("t6_d5", data_5, 32'd56);
    idle(1'b1);
    idle(1'b1);
    check("t6_no_extra", out_valid, 1'b0);
`endif

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic r;
      logic v;
      logic o;
      logic f;
      r = ($urandom_range(0, 299) == 0);
      v = ($urandom_range(0, 3) != 0);
      o = ($urandom_range(0, 2) != 0);
      f = ($urandom_range(0, 15) == 0);
      cycle(v, $urandom, o, r, f, a);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
